tmds_align_controller: RTL and testbench

- Sequences word alignment of the TMDS receive path in the `clk` (pixel) domain.
- Watches the raw 10-bit channel-0 word from the clock-crossing stage and drives the `phase` select back to it.
- Steps through the ten bit phases until runs of blanking control tokens are seen reliably, then holds and supervises lock.
- Replaces the free-running phase counter with a settle/search/verify/lock state machine and diagnostics.

---
 rtl/tmds_pkg.sv | 24 ++
 rtl/tmds_ctrl_run_detector.sv | 42 ++++
 rtl/tmds_align_controller.sv | 122 ++++++++++++
 tb/tb_tmds_align_controller.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tmds_pkg.sv
// Shared TMDS alignment constants: control tokens, FSM state encoding, phase range.
// Pure declarations; no latency, no flow control.
package tmds_pkg;

  localparam logic [9:0] CTRL_00 = 10'h354;
  localparam logic [9:0] CTRL_01 = 10'h0AB;
  localparam logic [9:0] CTRL_10 = 10'h154;
  localparam logic [9:0] CTRL_11 = 10'h2AB;

  localparam logic [3:0] PHASE_MAX = 4'd9;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETTLE = 3'd1,
    ST_SEARCH = 3'd2,
    ST_VERIFY = 3'd3,
    ST_LOCKED = 3'd4
  } state_e;

  function automatic logic is_ctrl(input logic [9:0] w);
    return (w == CTRL_00) || (w == CTRL_01) || (w == CTRL_10) || (w == CTRL_11);
  endfunction

endpackage

// File: rtl/tmds_ctrl_run_detector.sv
// Counts consecutive control tokens; pulses run_event MIN_RUN+1 cycles after a run's first token.
// No backpressure: consumes one word every cycle; clear holds the count at zero.
module tmds_ctrl_run_detector
  import tmds_pkg::*;
#(
  parameter int MIN_RUN = 8
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       clear,
  input  logic [9:0] word,
  output logic       run_event
);

  logic [7:0] run_len;
  logic       step;
  logic       match;

  assign match = is_ctrl(word);

  // step marks the MIN_RUN-1 -> MIN_RUN transition, so one pulse per run
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      run_len   <= '0;
      step      <= 1'b0;
      run_event <= 1'b0;
    end else if (clear) begin
      run_len   <= '0;
      step      <= 1'b0;
      run_event <= 1'b0;
    end else begin
      if (!match) begin
        run_len <= '0;
      end else if (run_len != 8'(MIN_RUN)) begin
        run_len <= run_len + 8'd1;
      end
      step      <= match && (run_len == 8'(MIN_RUN - 1));
      run_event <= step;
    end
  end

endmodule

// File: rtl/tmds_align_controller.sv
// Word-alignment sequencer: settles, searches phases for blanking runs, verifies, then supervises lock.
// Decisions take effect one cycle after run_event/timeout; no backpressure, word sampled every cycle.
module tmds_align_controller
  import tmds_pkg::*;
#(
  parameter int TIMEOUT_BITS  = 18,
  parameter int MIN_RUN       = 8,
  parameter int VERIFY_COUNT  = 4,
  parameter int SETTLE_CYCLES = 16,
  parameter int MISS_LIMIT    = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       pll_locked,
  input  logic [9:0] word,
  output logic [3:0] phase,
  output logic       locked,
  output logic [2:0] state,
  output logic       run_event,
  output logic [7:0] slip_count
);

  state_e                  cur;
  state_e                  nxt;
  logic [TIMEOUT_BITS-1:0] tcnt;
  logic [7:0]              settle_cnt;
  logic [3:0]              verify_cnt;
  logic [3:0]              verify_nxt;
  logic [3:0]              miss_cnt;
  logic [3:0]              miss_nxt;
  logic                    slip;
  logic                    expire;
  logic                    det_clear;

  assign expire    = &tcnt;
  assign det_clear = !pll_locked || (cur == ST_IDLE) || (cur == ST_SETTLE);
  assign state     = cur;

  tmds_ctrl_run_detector #(
    .MIN_RUN (MIN_RUN)
  ) u_run_det (
    .clk       (clk),
    .reset_n   (reset_n),
    .clear     (det_clear),
    .word      (word),
    .run_event (run_event)
  );

  always_comb begin
    nxt        = cur;
    verify_nxt = verify_cnt;
    miss_nxt   = miss_cnt;
    slip       = 1'b0;
    if (!pll_locked) begin
      nxt        = ST_IDLE;
      verify_nxt = '0;
      miss_nxt   = '0;
    end else begin
      case (cur)
        ST_IDLE:   nxt = ST_SETTLE;
        ST_SETTLE: if (settle_cnt == 8'(SETTLE_CYCLES - 1)) nxt = ST_SEARCH;
        ST_SEARCH: begin
          if (run_event) begin
            verify_nxt = 4'd1;
            nxt        = (VERIFY_COUNT == 1) ? ST_LOCKED : ST_VERIFY;
          end else if (expire) begin
            slip = 1'b1;
            nxt  = ST_SETTLE;
          end
        end
        ST_VERIFY: begin
          if (run_event) begin
            verify_nxt = verify_cnt + 4'd1;
            if (verify_cnt + 4'd1 == 4'(VERIFY_COUNT)) nxt = ST_LOCKED;
          end else if (expire) begin
            slip = 1'b1;
            nxt  = ST_SETTLE;
          end
        end
        ST_LOCKED: begin
          // a lost lock re-searches from the current phase rather than slipping
          if (run_event) begin
            miss_nxt = '0;
          end else if (expire) begin
            if (miss_cnt + 4'd1 == 4'(MISS_LIMIT)) begin
              miss_nxt = '0;
              nxt      = ST_SEARCH;
            end else begin
              miss_nxt = miss_cnt + 4'd1;
            end
          end
        end
        default:   nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cur        <= ST_IDLE;
      tcnt       <= '0;
      settle_cnt <= '0;
      verify_cnt <= '0;
      miss_cnt   <= '0;
      phase      <= '0;
      slip_count <= '0;
      locked     <= 1'b0;
    end else begin
      cur        <= nxt;
      verify_cnt <= verify_nxt;
      miss_cnt   <= miss_nxt;
      locked     <= (nxt == ST_LOCKED);
      tcnt       <= (!pll_locked || (nxt != cur) || run_event) ? '0 : tcnt + 1'b1;
      settle_cnt <= ((cur == ST_SETTLE) && (nxt == ST_SETTLE)) ? settle_cnt + 8'd1 : '0;
      if (slip) begin
        phase <= (phase == PHASE_MAX) ? 4'd0 : phase + 4'd1;
        if (slip_count != 8'hFF) slip_count <= slip_count + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_tmds_align_controller.sv
// Bench for tmds_align_controller with small timing parameters.
module tb_tmds_align_controller;

  localparam int TB   = 6;
  localparam int MR   = 4;
  localparam int VC   = 2;
  localparam int SC   = 3;
  localparam int ML   = 2;
  localparam int WRAP = 1 << TB;
  localparam logic [9:0] D = 10'h1F0;

  localparam int S_IDLE = 0, S_SETTLE = 1, S_SEARCH = 2, S_VERIFY = 3, S_LOCKED = 4;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       pll_locked = 1'b1;
  logic [9:0] word = 10'h354;
  logic [3:0] phase;
  logic       locked;
  logic [2:0] state;
  logic       run_event;
  logic [7:0] slip_count;

  int errors = 0;
  int checks = 0;
  int ev_seen = 0;

  always #5 clk = ~clk;

  tmds_align_controller #(
    .TIMEOUT_BITS (TB),
    .MIN_RUN      (MR),
    .VERIFY_COUNT (VC),
    .SETTLE_CYCLES(SC),
    .MISS_LIMIT   (ML)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .pll_locked (pll_locked),
    .word       (word),
    .phase      (phase),
    .locked     (locked),
    .state      (state),
    .run_event  (run_event),
    .slip_count (slip_count)
  );

  // Reference: time-stamp based timeouts, unsaturated token streak.
  int m_st, m_phase, m_slip, m_verify, m_miss, m_ncyc, m_tclr, m_settle0, m_streak;
  bit m_locked, m_runev, m_hit;

  function automatic bit is_tok(input logic [9:0] w);
    return (w == 10'h354) || (w == 10'h0AB) || (w == 10'h154) || (w == 10'h2AB);
  endfunction

  task automatic model_reset();
    m_st = S_IDLE; m_phase = 0; m_slip = 0; m_verify = 0; m_miss = 0;
    m_tclr = m_ncyc; m_settle0 = m_ncyc; m_streak = 0;
    m_locked = 0; m_runev = 0; m_hit = 0;
  endtask

  task automatic model_slip();
    m_phase = (m_phase + 1) % 10;
    if (m_slip < 255) m_slip++;
  endtask

  task automatic model_step(input bit p, input logic [9:0] w);
    bit clr, ev, ex;
    int nst, t;
    clr = !p || m_st == S_IDLE || m_st == S_SETTLE;
    ev  = m_runev;
    t   = m_ncyc - m_tclr;
    ex  = (t % WRAP) == WRAP - 1;
    nst = m_st;
    if (!p) begin
      nst = S_IDLE; m_verify = 0; m_miss = 0;
    end else begin
      case (m_st)
        S_IDLE:   nst = S_SETTLE;
        S_SETTLE: if (m_ncyc - m_settle0 == SC - 1) nst = S_SEARCH;
        S_SEARCH: begin
          if (ev) begin m_verify = 1; nst = (VC == 1) ? S_LOCKED : S_VERIFY; end
          else if (ex) begin model_slip(); nst = S_SETTLE; end
        end
        S_VERIFY: begin
          if (ev) begin m_verify++; if (m_verify == VC) nst = S_LOCKED; end
          else if (ex) begin model_slip(); nst = S_SETTLE; end
        end
        S_LOCKED: begin
          if (ev) m_miss = 0;
          else if (ex) begin
            m_miss++;
            if (m_miss == ML) begin m_miss = 0; nst = S_SEARCH; end
          end
        end
        default:  nst = S_IDLE;
      endcase
    end
    if (!p || nst != m_st || ev) m_tclr = m_ncyc + 1;
    if (nst == S_SETTLE && m_st != S_SETTLE) m_settle0 = m_ncyc + 1;
    m_runev = !clr && m_hit;
    if (clr || !is_tok(w)) m_streak = 0; else m_streak++;
    m_hit    = !clr && (m_streak == MR);
    m_st     = nst;
    m_locked = (nst == S_LOCKED);
    m_ncyc++;
  endtask

  task automatic cmp_model();
    checks++;
    if (state !== 3'(m_st) || phase !== 4'(m_phase) || locked !== m_locked ||
        run_event !== m_runev || slip_count !== 8'(m_slip)) begin
      errors++;
      $display("FAIL model cyc=%0d got st=%0d ph=%0d lk=%0b ev=%0b slip=%0d expected st=%0d ph=%0d lk=%0b ev=%0b slip=%0d",
               m_ncyc, state, phase, locked, run_event, slip_count,
               m_st, m_phase, m_locked, m_runev, m_slip);
    end
  endtask

  task automatic chk(input string name, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
    end
  endtask

  task automatic cyc(input bit p, input logic [9:0] w);
    pll_locked = p;
    word       = w;
    @(posedge clk);
    model_step(p, w);
    #1;
    cmp_model();
    if (run_event) ev_seen++;
  endtask

  task automatic wait_state(input int s, input string tag);
    int n;
    n = 0;
    while (state != 3'(s) && n < 50) begin cyc(1'b1, D); n++; end
    chk(tag, state, s);
  endtask

  // Two separate runs; the second is long and must still pulse only once.
  task automatic lock_runs(output int pulses);
    int e0;
    e0 = ev_seen;
    repeat (4) cyc(1'b1, 10'h354);
    repeat (3) cyc(1'b1, D);
    repeat (9) cyc(1'b1, 10'h2AB);
    repeat (3) cyc(1'b1, D);
    pulses = ev_seen - e0;
  endtask

  typedef struct {
    int         rep;
    bit         p;
    logic [9:0] w;
    int         st;
    int         lk;
    int         ev;
    int         ph;
    int         sl;
  } vec_t;

  vec_t       tbl[9];
  logic [9:0] toks[4];

  initial begin
    int n, len, kind, prev, pulses;
    bit lk_seen;

    tbl[0] = '{1, 1'b1, D,       S_SETTLE, 0, 0, 0, 0};
    tbl[1] = '{3, 1'b1, D,       S_SEARCH, 0, 0, 0, 0};
    tbl[2] = '{4, 1'b1, 10'h354, S_SEARCH, 0, 0, 0, 0};
    tbl[3] = '{1, 1'b1, D,       S_SEARCH, 0, 1, 0, 0};
    tbl[4] = '{1, 1'b1, 10'h0F3, S_VERIFY, 0, 0, 0, 0};
    tbl[5] = '{8, 1'b1, D,       S_VERIFY, 0, 0, 0, 0};
    tbl[6] = '{4, 1'b1, 10'h2AB, S_VERIFY, 0, 0, 0, 0};
    tbl[7] = '{1, 1'b1, D,       S_VERIFY, 0, 1, 0, 0};
    tbl[8] = '{1, 1'b1, D,       S_LOCKED, 1, 0, 0, 0};
    toks[0] = 10'h354; toks[1] = 10'h0AB; toks[2] = 10'h154; toks[3] = 10'h2AB;

    m_ncyc = 0;
    model_reset();
    #23;
    chk("rst_phase", phase, 0);
    chk("rst_locked", locked, 0);
    chk("rst_state", state, 0);
    chk("rst_slip", slip_count, 0);
    chk("rst_event", run_event, 0);
    reset_n = 1'b1;

    for (int i = 0; i < 9; i++) begin
      for (int r = 0; r < tbl[i].rep; r++) cyc(tbl[i].p, tbl[i].w);
      chk($sformatf("vec%0d_state", i), state, tbl[i].st);
      chk($sformatf("vec%0d_locked", i), locked, tbl[i].lk);
      chk($sformatf("vec%0d_event", i), run_event, tbl[i].ev);
      chk($sformatf("vec%0d_phase", i), phase, tbl[i].ph);
      chk($sformatf("vec%0d_slip", i), slip_count, tbl[i].sl);
    end

    repeat (127) cyc(1'b1, D);
    chk("lol_still_locked", locked, 1);
    cyc(1'b1, D);
    chk("lol_state", state, S_SEARCH);
    chk("lol_locked", locked, 0);
    chk("lol_phase", phase, 0);
    repeat (4) cyc(1'b1, 10'h154);
    repeat (2) cyc(1'b1, D);
    chk("lol_reverify", state, S_VERIFY);

    prev = phase;
    lk_seen = 0;
    for (int k = 1; k <= 10; k++) begin
      n = 0;
      while (phase == 4'(prev) && n < 200) begin
        cyc(1'b1, D);
        n++;
        if (locked) lk_seen = 1;
      end
      chk($sformatf("wrap%0d_phase", k), phase, k % 10);
      chk($sformatf("wrap%0d_period", k), n, (k == 1) ? WRAP : WRAP + SC);
      prev = phase;
    end
    chk("wrap_slip", slip_count, 10);
    chk("wrap_never_locked", lk_seen, 0);

    wait_state(S_SEARCH, "coll_search");
    repeat (58) cyc(1'b1, D);
    repeat (4) cyc(1'b1, 10'h0AB);
    cyc(1'b1, D);
    chk("coll_event", run_event, 1);
    cyc(1'b1, D);
    chk("coll_state", state, S_VERIFY);
    chk("coll_phase", phase, 0);
    chk("coll_slip", slip_count, 10);

    n = 0;
    while (phase != 4'd5 && n < 600) begin cyc(1'b1, D); n++; end
    chk("p5_phase", phase, 5);
    wait_state(S_SEARCH, "p5_search");
    lock_runs(pulses);
    chk("p5_pulses", pulses, 2);
    chk("p5_locked", locked, 1);
    cyc(1'b0, D);
    chk("pll_state", state, S_IDLE);
    chk("pll_locked_out", locked, 0);
    chk("pll_phase", phase, 5);
    cyc(1'b1, D);
    chk("pll_settle", state, S_SETTLE);
    wait_state(S_SEARCH, "pll_search");
    lock_runs(pulses);
    chk("relock_locked", locked, 1);
    chk("relock_phase", phase, 5);
    chk("relock_slip", slip_count, 15);

    reset_n = 1'b0;
    #2;
    chk("arst_phase", phase, 0);
    chk("arst_state", state, 0);
    chk("arst_locked", locked, 0);
    chk("arst_slip", slip_count, 0);
    model_reset();
    reset_n = 1'b1;

    for (int s = 0; s < 300; s++) begin
      kind = $urandom_range(0, 9);
      if (kind < 4) begin
        len = $urandom_range(1, 7);
        repeat (len) cyc(1'b1, toks[$urandom_range(0, 3)]);
      end else if (kind < 8) begin
        len = $urandom_range(1, 12);
        repeat (len) cyc(1'b1, 10'($urandom));
      end else if (kind == 8) begin
        len = $urandom_range(1, 3);
        repeat (len) cyc(1'b0, 10'($urandom));
      end else begin
        len = $urandom_range(10, 70);
        repeat (len) cyc(1'b1, D);
      end
      if (s % 100 == 99) begin
        reset_n = 1'b0;
        #2;
        chk("rand_arst_state", state, 0);
        model_reset();
        reset_n = 1'b1;
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
